// File: rtl/serial_add_seq.sv
`timescale 1ns/1ps
// serial_add_seq: WIDTH-bit adder that time-multiplexes an external 2-bit ripple adder.
// Latency: out_valid rises WIDTH/2 cycles after the accepting edge.
// Backpressure: one operation in flight; in_ready low until the held result is taken.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake; in_a, in_b, in_cin are the operands
//   slice_a/b/cin (out)     current 2-bit slice sent to the external adder
//   slice_s/cout (in)       combinational result returned by the external adder
//   out_valid/out_ready     result handshake; out_sum, out_cout, out_ovf held while valid
//
// Optional feature: define SERIAL_ADD_OVF_EN to compute the two's-complement
// overflow flag; without it out_ovf is tied to 0.
// WIDTH must be even and at least 2.

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    output logic             slice_cin,
    input  logic [1:0]       slice_s,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int HALF = WIDTH / 2;
    // Counter must be at least one bit wide even when WIDTH == 2.
    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [WIDTH+1:0] w_sum_cat;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_run     = (r_state == RUN);
    assign w_last    = w_run && (r_cnt == LAST);
    // New slice enters at the top; LSB slices migrate down as later ones arrive.
    assign w_sum_cat = {slice_s, r_sum};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        slice_a   = 2'b00;
        slice_b   = 2'b00;
        slice_cin = 1'b0;
        out_cout  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
            end
            RUN: begin
                slice_a   = r_a[1:0];
                slice_b   = r_b[1:0];
                slice_cin = r_carry;
            end
            DONE: begin
                out_valid = 1'b1;
                // After the last slice the carry register holds the final carry-out.
                out_cout  = r_carry;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> 2;
            r_b     <= r_b >> 2;
            r_sum   <= w_sum_cat[WIDTH+1:2];
            r_carry <= slice_cout;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign out_sum = r_sum;

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // Overflow = carry into the MSB xor carry out of the MSB. The carry into
    // the MSB is recovered from the top slice as a[1]^b[1]^s[1].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= slice_a[1] ^ slice_b[1] ^ slice_s[1] ^ slice_cout;
        end
    end

    assign out_ovf = r_ovf;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width in bits; WIDTH SHALL be even and >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning an operand set is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts operands this cycle.
REQ-006 The block SHALL have ports in_a and in_b, input, WIDTH bits each, the addends.
REQ-007 The block SHALL have port in_cin, input, 1 bit, the carry-in.
REQ-008 The block SHALL have ports slice_a and slice_b, output, 2 bits each, the current operand slice to the external 2-bit ripple adder.
REQ-009 The block SHALL have port slice_cin, output, 1 bit, the carry to the external 2-bit adder.
REQ-010 The block SHALL have port slice_s, input, 2 bits, the 2-bit sum returned by the external adder (combinational).
REQ-011 The block SHALL have port slice_cout, input, 1 bit, the carry returned by the external adder.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning the result is held.
REQ-013 The block SHALL have port out_ready, input, 1 bit, meaning downstream takes the result.
REQ-014 The block SHALL have port out_sum, output, WIDTH bits, the sum.
REQ-015 The block SHALL have port out_cout, output, 1 bit, the final carry-out.
REQ-016 The block SHALL have port out_ovf, output, 1 bit, the two's-complement overflow flag.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-019 On in_valid && in_ready, the block SHALL capture in_a, in_b, in_cin into shift and carry registers, clear slice counter to 0 and go to RUN.
REQ-020 In RUN, slice_a/slice_b SHALL be bits [1:0] of the operand shift registers and slice_cin SHALL be the carry register.
REQ-021 On each RUN edge, the block SHALL shift operands right by 2, shift slice_s into the top 2 bits of the sum register, load slice_cout into the carry register and increment the counter.
REQ-022 After WIDTH/2 RUN edges, the block SHALL enter DONE; out_valid SHALL rise exactly WIDTH/2 cycles after the accepting edge.
REQ-023 In DONE, out_sum, out_cout and out_ovf SHALL hold stable until out_valid && out_ready, then the FSM SHALL return to IDLE.
REQ-024 out_ready while not in DONE SHALL be ignored; in_valid while not in IDLE SHALL be ignored and the inputs SHALL not be sampled.
REQ-025 In IDLE and DONE, slice_a, slice_b and slice_cin SHALL be driven 0.
REQ-026 Sum SHALL be (in_a + in_b + in_cin) mod 2^WIDTH; out_cout SHALL be bit WIDTH of the full sum.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, in_ready 1, out_valid 0, out_sum 0, out_cout 0, out_ovf 0, counter 0, all slice outputs 0.
REQ-028 Reset asserted during RUN or DONE SHALL discard the operation; no out_valid SHALL follow the release of reset.

Configuration
REQ-029 With SERIAL_ADD_OVF_EN defined, out_ovf SHALL be latched on the last RUN edge as (slice_a[1]^slice_b[1]^slice_s[1]) XOR slice_cout.
REQ-030 Without SERIAL_ADD_OVF_EN, out_ovf SHALL be constant 0 and no overflow logic SHALL be present.

Verification (WIDTH=8)
REQ-031 0x5A+0x33, cin 0 -> out_sum 0x8D, out_cout 0, out_valid 4 cycles after accept.
REQ-032 0xFF+0x01, cin 0 -> out_sum 0x00, out_cout 1, out_ovf 0.
REQ-033 0x7F+0x01, cin 0 -> out_sum 0x80, out_ovf 1 with SERIAL_ADD_OVF_EN, 0 without.
REQ-034 0x00+0x00, cin 1, out_ready held 0 for 5 cycles -> out_sum 0x01 held stable, in_ready 0 throughout, IDLE one edge after out_ready 1.
REQ-035 rst_n pulsed low at RUN slice 2 -> outputs at reset values at once, no out_valid afterward; next op 0x10+0x20 -> 0x30.
